// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the staged UART reset sequencer.
// Soft-reset arbitration is compiled in only when RSTSEQ_SW_REQ_EN is defined.
package rstseq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rstseq_state_e;

    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int m;
        m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(m) + 1;
    endfunction

    function automatic bit params_ok(input int stages, input int hold_cycles,
                                     input int gap_cycles, input int req);
        return (stages >= 1) && (hold_cycles >= 1) && (gap_cycles >= 1) && (req >= 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the request vector, searching from a
// registered pointer that moves past the grantee whenever the grant is taken.
module rr_arbiter #(
    parameter int REQ = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [REQ-1:0] req,
    input  logic           advance,
    output logic [REQ-1:0] grant
);
    localparam int PTR_W = (REQ > 1) ? $clog2(REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    int               gidx;
    logic             found;

    always_comb begin
        grant = '0;
        gidx  = 0;
        found = 1'b0;
        for (int i = 0; i < REQ; i++) begin
            int j;
            j = (int'(ptr_q) + i) % REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                gidx     = j;
                grant[j] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance && found) ptr_d = PTR_W'((gidx + 1) % REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (baud gen, TX, RX) with hold/gap timing; software
// soft-reset requests are honoured only when RSTSEQ_SW_REQ_EN is defined.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int REQ         = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_reset_in,
    input  logic [REQ-1:0]    sw_req,
    output logic [STAGES-1:0] stage_reset,
    output logic              busy,
    output logic              done,
    output logic [REQ-1:0]    ack
);
    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = $clog2(STAGES + 1);

    if (!params_ok(STAGES, HOLD_CYCLES, GAP_CYCLES, REQ)) begin : g_bad_params
        $error("reset_sequencer: STAGES, HOLD_CYCLES, GAP_CYCLES and REQ must all be >= 1");
    end

    rstseq_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STAGES-1:0] stage_q, stage_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [REQ-1:0]    ack_q, ack_d;
    logic [REQ-1:0]    grant_q, grant_d;
    logic [REQ-1:0]    arb_grant;
    logic              arb_take;

`ifdef RSTSEQ_SW_REQ_EN
    rr_arbiter #(.REQ(REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (sw_req),
        .advance (arb_take),
        .grant   (arb_grant)
    );
`else
    // Pin kept for a fixed pinout; requests have no effect in this build.
    logic unused_sw_req;
    assign unused_sw_req = ^sw_req;
    assign arb_grant     = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stage_d  = stage_q;
        grant_d  = grant_q;
        done_d   = 1'b0;
        ack_d    = '0;
        arb_take = 1'b0;
        if (sync_reset_in) begin
            // Front-end reset restarts the sequence but keeps any pending grant.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '1;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    stage_d = '1;
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d    = ST_RELEASE;
                        stage_d[0] = 1'b0;
                        idx_d      = IDX_W'(1);
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (idx_q == IDX_W'(STAGES)) begin
                            state_d = ST_RUN;
                            stage_d = '0;
                            done_d  = 1'b1;
                            ack_d   = grant_q;
                            grant_d = '0;
                        end else begin
                            stage_d = stage_q & ~(STAGES'(1) << idx_q);
                            idx_d   = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    stage_d = '0;
                    if (grant_q != '0) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        idx_d   = '0;
                        stage_d = '1;
                    end else if (arb_grant != '0) begin
                        arb_take = 1'b1;
                        grant_d  = arb_grant;
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '1;
                end
            endcase
        end
        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
        end
    end

    assign stage_reset = stage_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack         = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer; soft-reset scenarios are selected by
// RSTSEQ_SW_REQ_EN, matching the build of the design.
module tb_reset_sequencer;
    localparam int STAGES = 3;
    localparam int HOLD   = 16;
    localparam int GAP    = 4;
    localparam int REQ    = 2;
    localparam int T_RUN  = HOLD + STAGES * GAP;
`ifdef RSTSEQ_SW_REQ_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sync_reset_in = 1'b0;
    logic [REQ-1:0]    sw_req = '0;
    logic [STAGES-1:0] stage_reset;
    logic              busy;
    logic              done;
    logic [REQ-1:0]    ack;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int edge_num  = 0;

    // Reference model: progress is "edges counted since the sequence last restarted".
    int                elapsed;
    int                m_ptr;
    logic [REQ-1:0]    m_grant;
    logic [STAGES-1:0] exp_stage;
    logic              exp_busy;
    logic              exp_done;
    logic [REQ-1:0]    exp_ack;

    always #5 clk = ~clk;

    reset_sequencer #(
        .STAGES(STAGES), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .REQ(REQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync_reset_in(sync_reset_in), .sw_req(sw_req),
        .stage_reset(stage_reset), .busy(busy), .done(done), .ack(ack)
    );

    task automatic model_outputs();
        for (int k = 0; k < STAGES; k++) exp_stage[k] = (elapsed < HOLD + k * GAP);
        exp_busy = (elapsed < T_RUN);
    endtask

    task automatic model_reset();
        elapsed  = 0;
        m_ptr    = 0;
        m_grant  = '0;
        exp_done = 1'b0;
        exp_ack  = '0;
        model_outputs();
    endtask

    task automatic model_edge(input logic s, input logic [REQ-1:0] r);
        bit found;
        exp_done = 1'b0;
        exp_ack  = '0;
        if (s) begin
            elapsed = 0;
        end else if (elapsed >= T_RUN) begin
            if (m_grant != '0) begin
                elapsed = 0;
            end else if (SW_EN && r != '0) begin
                found = 1'b0;
                for (int i = 0; i < REQ; i++) begin
                    int j;
                    j = (m_ptr + i) % REQ;
                    if (!found && r[j]) begin
                        found   = 1'b1;
                        m_grant = '0;
                        m_grant[j] = 1'b1;
                        m_ptr   = (j + 1) % REQ;
                    end
                end
            end
        end else begin
            elapsed++;
            if (elapsed == T_RUN) begin
                exp_done = 1'b1;
                exp_ack  = m_grant;
                m_grant  = '0;
            end
        end
        model_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(sync_reset_in, sw_req);
        #1;
        edge_num++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        sync_reset_in = 1'b0;
        sw_req        = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        edge_num = 0;
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++;
        if ({stage_reset, busy, done, ack} !== {{STAGES{1'b1}}, 1'b1, 1'b0, {REQ{1'b0}}})
            $display("FAIL reset_init: got stage=%b busy=%b done=%b ack=%b", stage_reset, busy, done, ack);
        else pass_cnt++;
        for (int i = 0; i < T_RUN + 2; i++) tick();
        // Asynchronous reset from RUN, checked before any clock edge arrives.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_cnt++;
        if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
            $display("FAIL reset_async: got stage=%b busy=%b done=%b ack=%b exp stage=%b busy=%b",
                     stage_reset, busy, done, ack, exp_stage, exp_busy);
        else pass_cnt++;
    endtask

    task automatic test_power_up();
        logic [STAGES-1:0] lit;
        do_reset();
        for (int i = 0; i < T_RUN + 4; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
                $display("FAIL power_up edge %0d: got stage=%b busy=%b done=%b ack=%b exp stage=%b busy=%b done=%b ack=%b",
                         edge_num, stage_reset, busy, done, ack, exp_stage, exp_busy, exp_done, exp_ack);
            else pass_cnt++;
            if (edge_num == 16 || edge_num == 20 || edge_num == 24) begin
                lit = (edge_num == 16) ? 3'b110 : (edge_num == 20) ? 3'b100 : 3'b000;
                check_cnt++;
                if (stage_reset !== lit)
                    $display("FAIL power_up_sched edge %0d: got %b exp %b", edge_num, stage_reset, lit);
                else pass_cnt++;
            end
            if (edge_num == 28) begin
                check_cnt++;
                if ({done, busy} !== 2'b10)
                    $display("FAIL power_up_run edge 28: got done=%b busy=%b exp done=1 busy=0", done, busy);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_front_end();
        int done_edge;
        done_edge = -1;
        do_reset();
        for (int i = 0; i < 120 && done_edge < 0; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
                $display("FAIL front_end edge %0d: got stage=%b busy=%b done=%b exp stage=%b busy=%b done=%b",
                         edge_num, stage_reset, busy, done, exp_stage, exp_busy, exp_done);
            else pass_cnt++;
            if (done) done_edge = edge_num;
            if (edge_num == 21) sync_reset_in = 1'b1;
            if (edge_num == 26) sync_reset_in = 1'b0;
        end
        check_cnt++;
        if (done_edge != 26 + T_RUN)
            $display("FAIL front_end_run_edge: got %0d exp %0d", done_edge, 26 + T_RUN);
        else pass_cnt++;
    endtask

`ifdef RSTSEQ_SW_REQ_EN
    task automatic test_soft_reset();
        int t0, ack_edge;
        ack_edge = -1;
        do_reset();
        for (int i = 0; i < T_RUN; i++) tick();
        sw_req = 2'b10;
        t0 = edge_num + 1;
        for (int i = 0; i < 3 * T_RUN && ack_edge < 0; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
                $display("FAIL soft_reset edge %0d: got stage=%b busy=%b done=%b ack=%b exp stage=%b busy=%b done=%b ack=%b",
                         edge_num, stage_reset, busy, done, ack, exp_stage, exp_busy, exp_done, exp_ack);
            else pass_cnt++;
            if (edge_num == t0 + 1) begin
                check_cnt++;
                if (stage_reset !== '1) $display("FAIL soft_reset_assert: got %b exp 111", stage_reset);
                else pass_cnt++;
            end
            if (ack != '0) begin
                ack_edge = edge_num;
                check_cnt++;
                if ({ack, done} !== 3'b101) $display("FAIL soft_reset_ack: got ack=%b done=%b exp ack=10 done=1", ack, done);
                else pass_cnt++;
                sw_req = sw_req & ~ack;
            end
        end
        check_cnt++;
        if (ack_edge != t0 + 1 + T_RUN) $display("FAIL soft_reset_latency: got edge %0d exp %0d", ack_edge, t0 + 1 + T_RUN);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) tick();
        check_cnt++;
        if ({busy, ack} !== 3'b000) $display("FAIL soft_reset_stay_run: got busy=%b ack=%b exp 0 00", busy, ack);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [REQ-1:0] seen[$];
        logic [REQ-1:0] want[3];
        int dones;
        want  = '{2'b01, 2'b10, 2'b01};
        dones = 0;
        do_reset();
        for (int i = 0; i < T_RUN; i++) tick();
        dones  = 1;
        sw_req = 2'b11;
        for (int i = 0; i < 5 * T_RUN && seen.size() < 3; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
                $display("FAIL round_robin edge %0d: got stage=%b busy=%b done=%b ack=%b exp stage=%b busy=%b done=%b ack=%b",
                         edge_num, stage_reset, busy, done, ack, exp_stage, exp_busy, exp_done, exp_ack);
            else pass_cnt++;
            if (done) dones++;
            if (ack != '0) seen.push_back(ack);
        end
        check_cnt++;
        if (seen.size() != 3 || dones != 4)
            $display("FAIL round_robin_count: got acks=%0d dones=%0d exp acks=3 dones=4", seen.size(), dones);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            check_cnt++;
            if (i >= seen.size() || seen[i] !== want[i])
                $display("FAIL round_robin_order[%0d]: got %b exp %b", i, (i < seen.size()) ? seen[i] : 2'bxx, want[i]);
            else pass_cnt++;
        end
        sw_req = '0;
    endtask

    task automatic test_abort();
        int acks, pulsed;
        acks   = 0;
        pulsed = 0;
        do_reset();
        for (int i = 0; i < T_RUN; i++) tick();
        sw_req = 2'b01;
        for (int i = 0; i < 4 * T_RUN && acks == 0; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
                $display("FAIL abort edge %0d: got stage=%b busy=%b done=%b ack=%b exp stage=%b busy=%b done=%b ack=%b",
                         edge_num, stage_reset, busy, done, ack, exp_stage, exp_busy, exp_done, exp_ack);
            else pass_cnt++;
            if (ack != '0) begin
                acks++;
                sw_req = sw_req & ~ack;
            end
            if (!pulsed && busy && elapsed == HOLD + GAP + 1) begin
                sync_reset_in = 1'b1;
                pulsed = 1;
            end else begin
                sync_reset_in = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack != '0) acks++;
        end
        check_cnt++;
        if (acks != 1 || pulsed != 1) $display("FAIL abort_ack_once: got acks=%0d pulsed=%0d exp 1 1", acks, pulsed);
        else pass_cnt++;
    endtask
`else
    task automatic test_macro_off();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < T_RUN; i++) tick();
        sw_req = 2'b11;
        for (int i = 0; i < 2 * T_RUN; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {{STAGES{1'b0}}, 1'b0, 1'b0, {REQ{1'b0}}})
                $display("FAIL macro_off edge %0d: got stage=%b busy=%b done=%b ack=%b exp all 0",
                         edge_num, stage_reset, busy, done, ack);
            else pass_cnt++;
        end
        sw_req = '0;
    endtask
`endif

    task automatic test_random();
        int sync_left;
        sync_left = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tick();
            check_cnt++;
            if ({stage_reset, busy, done, ack} !== {exp_stage, exp_busy, exp_done, exp_ack})
                $display("FAIL random edge %0d: got stage=%b busy=%b done=%b ack=%b exp stage=%b busy=%b done=%b ack=%b",
                         edge_num, stage_reset, busy, done, ack, exp_stage, exp_busy, exp_done, exp_ack);
            else pass_cnt++;
            sw_req = sw_req & ~ack;
            if ($urandom_range(0, 11) == 0) sw_req[$urandom_range(0, REQ - 1)] = 1'b1;
            if (sync_left > 0) sync_left--;
            else if ($urandom_range(0, 119) == 0) sync_left = $urandom_range(1, 4);
            sync_reset_in = (sync_left > 0);
        end
        sync_reset_in = 1'b0;
        sw_req = '0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_front_end();
`ifdef RSTSEQ_SW_REQ_EN
        test_soft_reset();
        test_round_robin();
        test_abort();
`else
        test_macro_off();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences orderly, staged reset release for the UART datapath. Takes the synchronised active-high reset produced by the async-reset front end and releases per-block resets one at a time (baud generator, then TX, then RX) with programmable hold and gap times. Optionally arbitrates software soft-reset requests from several requesters and replays the same sequence for each grant.

## Interface
Parameters:
- STAGES, 3: number of staged reset outputs; must be at least 1.
- HOLD_CYCLES, 16: cycles all stages stay asserted after reset cause clears; must be at least 1.
- GAP_CYCLES, 4: cycles between successive stage releases; must be at least 1.
- REQ, 2: number of soft-reset requesters; must be at least 1.

Ports:
- clk  in  1  single clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- sync_reset_in  in  1  synchronised active-high reset from the front end; highest priority.
- sw_req  in  REQ  level soft-reset requests; each held by its requester until the matching ack.
- stage_reset  out  STAGES  active-high resets; bit 0 is released first.
- busy  out  1  high whenever not in RUN.
- done  out  1  one-cycle pulse on entry to RUN.
- ack  out  REQ  one-cycle pulse to the granted requester on RUN entry.

## Operation
- FSM states: ASSERT, RELEASE, RUN.
- ASSERT: all stage_reset=1 and busy=1. cnt holds at 0 while sync_reset_in=1 and increments while it is 0. When cnt==HOLD_CYCLES-1 with sync_reset_in=0, the next edge:
  - moves to RELEASE,
  - clears stage_reset[0],
  - sets idx=1 and cnt=0.
- RELEASE: cnt counts to GAP_CYCLES-1.
  - At that count with idx<STAGES: clear stage_reset[idx], idx++, cnt=0.
  - At that count with idx==STAGES: go to RUN and pulse done.
- RUN: busy=0 and stage_reset=0.
  - Any sw_req bit set: rr_arbiter grants one requester (round-robin, pointer starts at 0 and advances past the last grantee). The grant is registered and the FSM goes to ASSERT on the next edge.
- ack[g] pulses for the registered grant on the same edge done pulses, then the grant clears.
- sync_reset_in=1 in any state: next edge forces ASSERT, all stage_reset=1, cnt=0, idx=0. An existing grant is kept, and its ack still fires at completion.
- Requests arriving while busy stay pending (level) and are arbitrated only in RUN. Exactly one grant is issued per sequence.
- Counter width is clog2(max(HOLD_CYCLES,GAP_CYCLES))+1. Counters never wrap; they saturate only via state exit.

## Timing
- rst_n=0, asynchronously:
  - state=ASSERT, stage_reset all 1, busy=1, done=0, ack=0, cnt=0, idx=0, grant cleared, rr pointer=0.
- Edge numbering: edge 1 is the first rising clk with rst_n=1 and sync_reset_in=0.
- Release schedule:
  - stage_reset[k] falls after edge HOLD_CYCLES + k·GAP_CYCLES.
  - RUN, done, and ack are entered/pulsed after edge HOLD_CYCLES + STAGES·GAP_CYCLES.
  - Defaults: edges 16, 20, 24 release the stages; RUN at edge 28.
- Soft-reset latency: sw_req seen in RUN at edge t means stage_reset all 1 after edge t+1, and ack after edge t+1+HOLD+STAGES·GAP.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- RSTSEQ_SW_REQ_EN defined:
  - sw_req, ack, rr_arbiter and grant logic are present as described.
- RSTSEQ_SW_REQ_EN undefined:
  - sw_req is ignored and ack is tied to 0.
  - RUN is left only via sync_reset_in or rst_n.
  - Ports remain for a fixed pinout.

## Structure
- Shared package rstseq_pkg holds:
  - state encodings (ASSERT=2'd0, RELEASE=2'd1, RUN=2'd2),
  - the counter-width function,
  - parameter legality checks.
- One sub-module, rr_arbiter (REQ-wide, registered pointer, one-hot grant). It is instantiated only under RSTSEQ_SW_REQ_EN.

## Test plan
- Power-up: rst_n low 3 cycles, then high, sync_reset_in=0 → stage_reset 3'b111 until edge 16, then 3'b110 at 16, 3'b100 at 20, 3'b000 at 24; done pulse at 28; busy low from 28.
- Front-end reset: sync_reset_in high 5 cycles starting at edge 22 → stage_reset back to 3'b111 next edge; counting resumes after it falls; RUN 28 edges after the fall.
- Soft reset: in RUN, sw_req=2'b10 held → all stages reasserted next edge; ack=2'b10 pulses with done 28 edges later; sw_req dropped → stays in RUN.
- Round-robin fairness: sw_req=2'b11 held continuously → acks alternate 01, 10, 01, with exactly one sequence per ack.
- Mid-sequence abort: sw_req[0] granted, sync_reset_in pulse during RELEASE → sequence restarts; ack[0] fires once at final RUN.
- Macro off: RSTSEQ_SW_REQ_EN undefined, sw_req=2'b11 in RUN → no state change, ack stays 0.
